// File: rtl/sdm_adc_ctrl.sv
// Sequencer for a sigma-delta decimation chain: oversampling strobe generation,
// chain reset/settle/drain control and a 1-deep PCM output buffer with overrun flag.
module sdm_adc_ctrl #(
  parameter int CLK_DIV        = 16,
  parameter int SETTLE_SAMPLES = 8,
  parameter int DRAIN_CYCLES   = 64,
  parameter int DW             = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 sdm_in,
  output logic                 sdm_out,
  output logic                 sdm_valid,
  output logic                 chain_rst_n,
  input  logic                 chain_valid,
  input  logic signed [DW-1:0] chain_data,
  output logic                 pcm_valid,
  output logic signed [DW-1:0] pcm_data,
  input  logic                 pcm_ready,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic [1:0]           state
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int SET_W = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_SAMPLES - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t           st;
  logic [DIV_W-1:0] div_cnt;
  logic [SET_W-1:0] settle_cnt;
  logic [DRN_W-1:0] drain_cnt;
  logic             run_word;
  logic             load;

  assign run_word = (st == S_RUN) && chain_valid;
  // A full buffer can take a new word in the same cycle its old word is accepted.
  assign load     = run_word && (!pcm_valid || pcm_ready);
  assign state    = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= S_IDLE;
      div_cnt     <= '0;
      settle_cnt  <= '0;
      drain_cnt   <= '0;
      sdm_out     <= 1'b0;
      sdm_valid   <= 1'b0;
      chain_rst_n <= 1'b0;
      pcm_valid   <= 1'b0;
      pcm_data    <= '0;
      overrun     <= 1'b0;
    end else begin
      sdm_valid <= 1'b0;
      case (st)
        S_IDLE: begin
          if (enable) begin
            st          <= S_SETTLE;
            chain_rst_n <= 1'b1;
            div_cnt     <= '0;
            settle_cnt  <= '0;
          end
        end
        S_SETTLE, S_RUN: begin
          if (!enable) begin
            // Divider is frozen here; no strobe is issued on the stopping edge.
            st        <= S_DRAIN;
            drain_cnt <= '0;
          end else begin
            if (div_cnt == DIV_LAST) begin
              div_cnt   <= '0;
              sdm_out   <= sdm_in;
              sdm_valid <= 1'b1;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
            if (st == S_SETTLE && chain_valid) begin
              if (settle_cnt == SET_LAST) st <= S_RUN;
              else settle_cnt <= settle_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRN_LAST) begin
            st          <= S_IDLE;
            chain_rst_n <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: st <= S_IDLE;
      endcase

      if (load) begin
        pcm_data  <= chain_data;
        pcm_valid <= 1'b1;
      end else if (pcm_ready) begin
        pcm_valid <= 1'b0;
      end

      if (run_word && pcm_valid && !pcm_ready) overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdm_adc_ctrl.sv
// Directed bench for sdm_adc_ctrl with CLK_DIV=4, SETTLE_SAMPLES=2, DRAIN_CYCLES=8.
module tb_sdm_adc_ctrl;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 enable = 1'b0;
  logic                 sdm_in = 1'b0;
  logic                 sdm_out;
  logic                 sdm_valid;
  logic                 chain_rst_n;
  logic                 chain_valid = 1'b0;
  logic signed [DW-1:0] chain_data = '0;
  logic                 pcm_valid;
  logic signed [DW-1:0] pcm_data;
  logic                 pcm_ready = 1'b0;
  logic                 overrun;
  logic                 overrun_clr = 1'b0;
  logic [1:0]           state;

  int checks = 0;
  int errors = 0;

  sdm_adc_ctrl #(.CLK_DIV(4), .SETTLE_SAMPLES(2), .DRAIN_CYCLES(8), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sdm_in(sdm_in),
    .sdm_out(sdm_out), .sdm_valid(sdm_valid), .chain_rst_n(chain_rst_n),
    .chain_valid(chain_valid), .chain_data(chain_data),
    .pcm_valid(pcm_valid), .pcm_data(pcm_data), .pcm_ready(pcm_ready),
    .overrun(overrun), .overrun_clr(overrun_clr), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({sdm_out, sdm_valid, chain_rst_n, pcm_valid, overrun} !== 5'b0 || pcm_data !== 16'h0 || state !== 2'd0) begin
      errors++;
      $display("FAIL reset: out=%b vld=%b crst=%b pv=%b ov=%b data=%h st=%0d required all zero",
               sdm_out, sdm_valid, chain_rst_n, pcm_valid, overrun, pcm_data, state);
    end
  endtask

  task automatic test_strobes();
    logic [3:0] k;
    logic       exp_out;
    enable = 1'b1;
    step();
    checks++;
    if (state !== 2'd1 || chain_rst_n !== 1'b1 || sdm_valid !== 1'b0) begin
      errors++;
      $display("FAIL start: st=%0d crst=%b vld=%b required 1 1 0", state, chain_rst_n, sdm_valid);
    end
    exp_out = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      k = 4'(i);
      sdm_in = k[2];
      if (k[1:0] == 2'd0) exp_out = k[2];
      step();
      checks++;
      if (sdm_valid !== (k[1:0] == 2'd0) || sdm_out !== exp_out) begin
        errors++;
        $display("FAIL strobe[%0d]: vld=%b out=%b required %b %b", i, sdm_valid, sdm_out,
                 (k[1:0] == 2'd0), exp_out);
      end
    end
  endtask

  task automatic test_settle();
    chain_valid = 1'b1; chain_data = 16'h0011;
    step();
    checks++;
    if (state !== 2'd1 || pcm_valid !== 1'b0) begin
      errors++;
      $display("FAIL settle1: st=%0d pv=%b required 1 0", state, pcm_valid);
    end
    chain_data = 16'h0022;
    step();
    checks++;
    if (state !== 2'd2 || pcm_valid !== 1'b0) begin
      errors++;
      $display("FAIL settle2: st=%0d pv=%b required 2 0", state, pcm_valid);
    end
    chain_data = 16'h1234;
    step();
    chain_valid = 1'b0;
    checks++;
    if (pcm_valid !== 1'b1 || pcm_data !== 16'h1234) begin
      errors++;
      $display("FAIL first_word: pv=%b data=%h required 1 1234", pcm_valid, pcm_data);
    end
    pcm_ready = 1'b1;
    step();
    pcm_ready = 1'b0;
    checks++;
    if (pcm_valid !== 1'b0) begin
      errors++;
      $display("FAIL accept: pv=%b required 0", pcm_valid);
    end
  endtask

  task automatic test_overrun();
    chain_valid = 1'b1; chain_data = 16'h0100;
    step();
    chain_data = 16'h0200;
    step();
    chain_valid = 1'b0;
    checks++;
    if (pcm_valid !== 1'b1 || pcm_data !== 16'h0100 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: pv=%b data=%h ov=%b required 1 0100 1", pcm_valid, pcm_data, overrun);
    end
    overrun_clr = 1'b1;
    step();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clr: ov=%b required 0", overrun);
    end
    chain_valid = 1'b1; chain_data = 16'h0300;
    step();
    chain_valid = 1'b0; overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b1 || pcm_data !== 16'h0100) begin
      errors++;
      $display("FAIL set_wins: ov=%b data=%h required 1 0100", overrun, pcm_data);
    end
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    pcm_ready = 1'b1; chain_valid = 1'b1; chain_data = 16'h7FFF;
    step();
    chain_valid = 1'b0;
    checks++;
    if (pcm_valid !== 1'b1 || pcm_data !== 16'h7FFF || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b: pv=%b data=%h ov=%b required 1 7fff 0", pcm_valid, pcm_data, overrun);
    end
    step();
    pcm_ready = 1'b0;
    checks++;
    if (pcm_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: pv=%b required 0", pcm_valid);
    end
    chain_valid = 1'b1; chain_data = 16'h0055;
    step();
    chain_valid = 1'b0;
  endtask

  task automatic test_drain();
    enable = 1'b0;
    step();
    checks++;
    if (state !== 2'd3 || sdm_valid !== 1'b0 || chain_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL drain_entry: st=%0d vld=%b crst=%b required 3 0 1", state, sdm_valid, chain_rst_n);
    end
    for (int i = 1; i <= 8; i++) begin
      chain_valid = 1'b1; chain_data = 16'h0999;
      enable = (i == 3);
      step();
      checks++;
      if (sdm_valid !== 1'b0 || pcm_valid !== 1'b1 || pcm_data !== 16'h0055 || overrun !== 1'b0 ||
          state !== ((i == 8) ? 2'd0 : 2'd3) || chain_rst_n !== (i != 8)) begin
        errors++;
        $display("FAIL drain[%0d]: vld=%b pv=%b data=%h ov=%b st=%0d crst=%b required 0 1 0055 0 %0d %b",
                 i, sdm_valid, pcm_valid, pcm_data, overrun, state, chain_rst_n,
                 (i == 8) ? 0 : 3, (i != 8));
      end
    end
    chain_valid = 1'b0; enable = 1'b0;
    step();
    checks++;
    if (state !== 2'd0 || pcm_valid !== 1'b1) begin
      errors++;
      $display("FAIL idle_hold: st=%0d pv=%b required 0 1", state, pcm_valid);
    end
    pcm_ready = 1'b1;
    step();
    pcm_ready = 1'b0;
    checks++;
    if (pcm_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_accept: pv=%b required 0", pcm_valid);
    end
  endtask

  task automatic test_async_reset();
    enable = 1'b1;
    step();
    chain_valid = 1'b1;
    step();
    step();
    chain_data = 16'h4321;
    step();
    chain_valid = 1'b0;
    checks++;
    if (state !== 2'd2 || pcm_valid !== 1'b1 || pcm_data !== 16'h4321) begin
      errors++;
      $display("FAIL pre_reset: st=%0d pv=%b data=%h required 2 1 4321", state, pcm_valid, pcm_data);
    end
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    enable = 1'b0;
    step();
    rst_n = 1'b1;
    test_strobes();
  endtask

  initial begin
    #2;
    test_reset();
    step();
    rst_n = 1'b1;
    test_strobes();
    test_settle();
    test_overrun();
    test_back_to_back();
    test_drain();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
